// File: rtl/viterbi_pkg.sv
// Shared types and width helpers for the Viterbi survivor-memory/traceback engine.
package viterbi_pkg;

  typedef enum logic [1:0] {IDLE, TRACE, DECODE, EMIT} tb_state_e;

  localparam int K_DEF       = 4;
  localparam int TB_LEN_DEF  = 16;
  localparam int DEC_LEN_DEF = 8;
  localparam int DEPTH_DEF   = 32;

  function automatic int state_w(input int k);
    return k - 1;
  endfunction

  localparam int SW_DEF    = state_w(K_DEF);
  localparam int NS_DEF    = 2 ** SW_DEF;
  localparam int PTR_W_DEF = $clog2(DEPTH_DEF);
  localparam int CNT_W_DEF = $clog2(DEPTH_DEF + 1);

endpackage

// File: rtl/surv_mem.sv
// Survivor decision store: one synchronous write port, one combinational read port.
module surv_mem #(
  parameter int DEPTH = 32,
  parameter int NS    = 8,
  parameter int PTR_W = 5
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [NS-1:0]    i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [NS-1:0]    o_rdata
);

  logic [NS-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/viterbi_tb_engine.sv
// Windowed traceback engine: buffers ACS decisions, traces back from the newest
// step and emits decoded bits oldest first, with end-of-stream flush.
module viterbi_tb_engine
  import viterbi_pkg::*;
#(
  parameter int K       = 4,
  parameter int TB_LEN  = 16,
  parameter int DEC_LEN = 8,
  parameter int DEPTH   = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        dec_valid,
  output logic                        dec_ready,
  input  logic [(2**state_w(K))-1:0]  dec_surv,
  input  logic [state_w(K)-1:0]       dec_best,
  input  logic                        dec_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_bit,
  output logic                        out_last,
  output logic                        busy
);

  localparam int SW     = state_w(K);
  localparam int NS     = 2 ** SW;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int OB_LEN = TB_LEN + DEC_LEN;
  localparam int OB_W   = $clog2(OB_LEN);

  if (K < 3 || DEPTH != (1 << PTR_W) || DEPTH < TB_LEN + 2 * DEC_LEN) begin : g_bad_params
    $error("viterbi_tb_engine: illegal parameter combination");
  end

  tb_state_e        r_state;
  logic [PTR_W-1:0] r_wp, r_last_a, r_a;
  logic [CNT_W-1:0] r_n_undec, r_tcnt, r_n_dec;
  logic [SW-1:0]    r_best_q, r_s;
  logic [OB_W-1:0]  r_j, r_e;
  logic [OB_LEN-1:0] r_obuf;
  logic             r_flush_pend, r_final;
  logic             r_out_valid, r_out_bit, r_out_last;

  logic             w_wr, w_release, w_emit_done;
  logic [NS-1:0]    w_rdata;
  logic [SW-1:0]    w_pred;

  surv_mem #(.DEPTH(DEPTH), .NS(NS), .PTR_W(PTR_W)) u_surv_mem (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wp),
    .i_wdata (dec_surv),
    .i_raddr (r_a),
    .o_rdata (w_rdata)
  );

  assign dec_ready   = (r_n_undec < CNT_W'(DEPTH)) && !r_flush_pend;
  assign w_wr        = dec_valid && dec_ready;
  assign w_release   = (r_state == DECODE) && (r_j == '0);
  assign w_emit_done = (CNT_W'(r_e) + CNT_W'(1)) == r_n_dec;
  assign w_pred      = {r_s[SW-2:0], w_rdata[r_s]};
  assign busy        = (r_state != IDLE) || r_flush_pend;
  assign out_valid   = r_out_valid;
  assign out_bit     = r_out_bit;
  assign out_last    = r_out_last;

  // Training depth spans every undecoded entry newer than the decode window, so
  // a launch always decodes the oldest DEC_LEN entries even if writes ran ahead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;  r_wp <= '0;  r_last_a <= '0;  r_a <= '0;
      r_n_undec <= '0;  r_tcnt <= '0;  r_n_dec <= '0;
      r_best_q <= '0;  r_s <= '0;  r_j <= '0;  r_e <= '0;
      r_flush_pend <= 1'b0;  r_final <= 1'b0;
      r_out_valid <= 1'b0;  r_out_bit <= 1'b0;  r_out_last <= 1'b0;
    end else if (clr) begin
      r_state <= IDLE;  r_wp <= '0;  r_last_a <= '0;  r_a <= '0;
      r_n_undec <= '0;  r_tcnt <= '0;  r_n_dec <= '0;
      r_best_q <= '0;  r_s <= '0;  r_j <= '0;  r_e <= '0;
      r_flush_pend <= 1'b0;  r_final <= 1'b0;
      r_out_valid <= 1'b0;  r_out_bit <= 1'b0;  r_out_last <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wp     <= r_wp + 1'b1;
        r_last_a <= r_wp;
        r_best_q <= dec_best;
        if (dec_last) r_flush_pend <= 1'b1;
      end
      r_n_undec <= r_n_undec + CNT_W'(w_wr) - (w_release ? r_n_dec : '0);

      case (r_state)
        IDLE: begin
          if (r_n_undec >= CNT_W'(OB_LEN)) begin
            r_a     <= r_last_a;
            r_s     <= r_best_q;
            r_tcnt  <= r_n_undec - CNT_W'(DEC_LEN);
            r_n_dec <= CNT_W'(DEC_LEN);
            r_j     <= OB_W'(DEC_LEN - 1);
            r_final <= 1'b0;
            r_state <= TRACE;
          end else if (r_flush_pend && r_n_undec != '0) begin
            r_a     <= r_last_a;
            r_s     <= r_best_q;
            r_tcnt  <= '0;
            r_n_dec <= r_n_undec;
            r_j     <= OB_W'(r_n_undec - 1'b1);
            r_final <= 1'b1;
            r_state <= DECODE;
          end
        end
        TRACE: begin
          r_a    <= r_a - 1'b1;
          r_s    <= w_pred;
          r_tcnt <= r_tcnt - 1'b1;
          if (r_tcnt == CNT_W'(1)) r_state <= DECODE;
        end
        DECODE: begin
          r_a <= r_a - 1'b1;
          r_s <= w_pred;
          r_j <= r_j - 1'b1;
          if (r_j == '0) begin
            r_e         <= '0;
            r_out_valid <= 1'b1;
            r_out_bit   <= r_s[SW-1];
            r_out_last  <= r_final && (r_n_dec == CNT_W'(1));
            r_state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (w_emit_done) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_state     <= IDLE;
              if (r_final) begin
                r_flush_pend <= 1'b0;
                r_wp         <= '0;
                r_n_undec    <= '0;
              end
            end else begin
              r_e        <= r_e + 1'b1;
              r_out_bit  <= r_obuf[r_e + 1'b1];
              r_out_last <= r_final && ((CNT_W'(r_e) + CNT_W'(2)) == r_n_dec);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Decode order is newest first, so the oldest bit lands in obuf[0].
  always_ff @(posedge clk) begin
    if (r_state == DECODE) r_obuf[r_j] <= r_s[SW-1];
  end

endmodule

// File: tb/tb_viterbi_tb_engine.sv
// Self-checking bench: random encoder paths with random off-path survivors,
// checked against the input bit sequence, plus latency, backpressure, flush and abort.
module tb_viterbi_tb_engine;
  localparam int K     = 4;
  localparam int SW    = K - 1;
  localparam int NS    = 2 ** SW;
  localparam int TB    = 16;
  localparam int DEC   = 8;
  localparam int DEPTH = 32;

  logic clk = 1'b0, rst = 1'b0, clr = 1'b0;
  logic dec_valid = 1'b0, dec_last = 1'b0, out_ready = 1'b0;
  logic [NS-1:0] dec_surv = '0;
  logic [SW-1:0] dec_best = '0;
  logic dec_ready, out_valid, out_bit, out_last, busy;

  viterbi_tb_engine #(.K(K), .TB_LEN(TB), .DEC_LEN(DEC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_surv(dec_surv),
    .dec_best(dec_best), .dec_last(dec_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int enc_st   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Encoder model: next state = {u, s >> 1}; the survivor bit of the true
  // state is the LSB of its true predecessor, everything else is noise.
  task automatic make_vec(input bit zero, output logic [NS-1:0] surv,
                          output logic [SW-1:0] best, output bit u);
    int prev;
    prev   = enc_st;
    u      = zero ? 1'b0 : 1'($urandom_range(0, 1));
    enc_st = (int'(u) << (SW - 1)) | (prev >> 1);
    surv   = zero ? '0 : NS'($urandom);
    surv[enc_st] = 1'(prev & 1);
    best   = SW'(enc_st);
  endtask

  task automatic do_clr();
    @(negedge clk);
    dec_valid = 1'b0; dec_last = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // vmode: 0 continuous valid, 1 random. rmode: 0 ready high, 1 random, 2 low until cycle 'stall'.
  task automatic run_stream(input int n, input bit flush, input bit zero, input int vmode,
                            input int rmode, input int stall, input string tag,
                            output int lat, output int acc_low);
    bit exp_q[$];
    int exp_cnt, sent, got, ecount, acc24, first_ov, idle;
    bit have_vec, flushed, u, prev_stall, prev_bit, prev_last;
    logic [NS-1:0] sv;
    logic [SW-1:0] bv;
    do_clr();
    enc_st = 0; sent = 0; got = 0; ecount = 0; acc24 = -1; first_ov = -1; idle = 0;
    have_vec = 0; flushed = 0; prev_stall = 0; prev_bit = 0; prev_last = 0; acc_low = -1;
    sv = '0; bv = '0;
    exp_cnt = flush ? n : ((n >= TB + DEC) ? DEC * ((n - TB) / DEC) : 0);
    while (ecount < 4000) begin
      @(negedge clk);
      if (!have_vec && sent < n) begin
        make_vec(zero, sv, bv, u);
        exp_q.push_back(u);
        have_vec = 1;
      end
      dec_valid = have_vec && (vmode == 0 || $urandom_range(0, 3) != 0);
      dec_surv  = sv;
      dec_best  = bv;
      dec_last  = flush && (sent == n - 1);
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : (ecount >= stall);
      #1;
      if (prev_stall) begin
        chk({tag, "_hold_valid"}, out_valid, 1);
        chk({tag, "_hold_bit"}, out_bit, prev_bit);
        chk({tag, "_hold_last"}, out_last, prev_last);
      end
      if (out_valid && first_ov < 0) first_ov = ecount - 1;
      if (rmode == 2 && !dec_ready && acc_low < 0 && !flushed) acc_low = sent;
      if (flushed && busy) chk({tag, "_ready_low_in_flush"}, dec_ready, 0);
      if (dec_valid && dec_ready) begin
        sent++;
        have_vec = 0;
        if (sent == TB + DEC) acc24 = ecount;
        if (dec_last) flushed = 1;
      end
      if (out_valid && out_ready) begin
        if (got < exp_cnt) begin
          chk({tag, "_bit"}, out_bit, exp_q[got]);
          chk({tag, "_last"}, out_last, (flush && got == n - 1));
        end else begin
          chk({tag, "_extra_bits"}, got + 1, exp_cnt);
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_bit   = out_bit;
      prev_last  = out_last;
      ecount++;
      if (sent == n && got >= exp_cnt && !(flush && busy)) idle++;
      else idle = 0;
      if (idle >= 50) break;
    end
    chk({tag, "_sent"}, sent, n);
    chk({tag, "_out_count"}, got, exp_cnt);
    if (flush) begin
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_ready_end"}, dec_ready, 1);
    end
    lat = (acc24 >= 0 && first_ov >= 0) ? first_ov - acc24 : -1;
    dec_valid = 1'b0; dec_last = 1'b0;
  endtask

  task automatic feed(input int n, input string tag);
    int acc, guard;
    logic [NS-1:0] sv;
    logic [SW-1:0] bv;
    bit u;
    acc = 0; guard = 0; enc_st = 0;
    while (acc < n && guard < 200) begin
      @(negedge clk);
      make_vec(0, sv, bv, u);
      dec_surv = sv; dec_best = bv; dec_valid = 1'b1; dec_last = 1'b0;
      #1;
      if (dec_ready) acc++;
      guard++;
    end
    @(negedge clk);
    dec_valid = 1'b0;
    chk({tag, "_feed"}, acc, n);
  endtask

  task automatic watch_quiet(input int cycles, input string tag);
    int nv;
    nv = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) nv++;
    end
    chk({tag, "_quiet"}, nv, 0);
  endtask

  initial begin
    int lat, acl, w;
    #1;
    chk("rst_dec_ready", dec_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_stream(40, 0, 1, 0, 0, 0, "zero", lat, acl);
    chk("zero_latency", lat, TB + DEC + 1);

    run_stream(64, 0, 0, 1, 1, 0, "path_rand", lat, acl);
    run_stream(48, 1, 0, 0, 0, 0, "path_flush", lat, acl);

    run_stream(60, 1, 0, 0, 2, 200, "bp", lat, acl);
    chk("bp_accepts_at_full", acl, DEPTH);

    run_stream(5, 1, 0, 0, 0, 0, "flush5", lat, acl);
    run_stream(30, 1, 0, 0, 1, 0, "flush30", lat, acl);

    // Asynchronous reset while the engine is training.
    do_clr();
    out_ready = 1'b1;
    feed(TB + DEC, "rst_abort");
    repeat (4) @(negedge clk);
    #1;
    chk("rst_abort_busy_before", busy, 1);
    chk("rst_abort_valid_before", out_valid, 0);
    #1 rst = 1'b0;
    #1;
    chk("rst_abort_valid", out_valid, 0);
    chk("rst_abort_ready", dec_ready, 1);
    chk("rst_abort_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    watch_quiet(40, "rst_abort");
    run_stream(20, 1, 0, 1, 1, 0, "post_rst", lat, acl);

    // Synchronous clear while a block is waiting to be emitted.
    do_clr();
    out_ready = 1'b0;
    feed(TB + DEC, "clr_abort");
    w = 0;
    while (!out_valid && w < 80) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("clr_abort_reached_emit", out_valid, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("clr_abort_valid", out_valid, 0);
    chk("clr_abort_ready", dec_ready, 1);
    chk("clr_abort_busy", busy, 0);
    out_ready = 1'b1;
    watch_quiet(40, "clr_abort");
    run_stream(40, 1, 0, 0, 0, 0, "post_clr", lat, acl);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
